// File: rtl/spram_bwe_init.sv
// Single-port RAM with byte write enables, 1-3 cycle read pipeline,
// selectable collision mode and a post-reset init sweep.
module spram_bwe_init #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH         = 128,
  parameter int                    BYTE_WIDTH    = 8,
  parameter int                    LATENCY       = 1,
  parameter string                 WRITE_MODE    = "write_first",
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  localparam int                   AW            = $clog2(DEPTH),
  localparam int                   NB            = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NB-1:0]         we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  ready
);

  localparam bit WF = (WRITE_MODE == "write_first");
  localparam bit RF = (WRITE_MODE == "read_first");
  localparam bit NC = (WRITE_MODE == "no_change");

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_lat
    $error("spram_bwe_init: LATENCY must be 1, 2 or 3");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $error("spram_bwe_init: DATA_WIDTH not a multiple of BYTE_WIDTH");
  end
  if (!(WF || RF || NC)) begin : g_bad_mode
    $error("spram_bwe_init: unknown WRITE_MODE");
  end

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  logic [AW-1:0]       cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  addr_ok;
  logic                  acc;
  logic                  has_we;
  logic                  init_wr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  cap_v;
  logic [DATA_WIDTH-1:0] cap_d;
  logic                  last_v;
  logic [DATA_WIDTH-1:0] last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_ON_RESET ? S_INIT : S_RUN;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      ready <= (state == S_RUN);
      if (state == S_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) begin
          state <= S_RUN;
          cnt   <= '0;
        end
      end
    end
  end

  assign addr_ok = ({1'b0, addr} < (AW+1)'(DEPTH));
  assign acc     = en && ready && addr_ok;
  assign has_we  = (we != '0);
  assign init_wr = (state == S_INIT);
  assign rd_word = mem[addr];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // The sweep owns the array while ready is low, so it never races an access.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt] <= INIT_VALUE;
    end else if (acc && has_we) begin
      mem[addr] <= merged;
    end
  end

  assign cap_v = acc && !(NC && has_we);
  assign cap_d = WF ? merged : rd_word;

  if (LATENCY == 1) begin : g_l1
    assign last_v = cap_v;
    assign last_d = cap_d;
  end else begin : g_ln
    logic [LATENCY-2:0]    pv;
    logic [DATA_WIDTH-1:0] pd [LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
      end else begin
        pv[0] <= cap_v;
        for (int i = 1; i < LATENCY - 1; i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= cap_d;
      for (int i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
    end

    assign last_v = pv[LATENCY-2];
    assign last_d = pd[LATENCY-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= last_v;
      if (last_v) dout <= last_d;
    end
  end

endmodule

// File: tb/tb_spram_bwe_init.sv
// Bench for spram_bwe_init: four configurations on a shared stimulus bus,
// checked against a calendar-based reference model plus directed tables.
module tb_spram_bwe_init;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = '0;
  logic [3:0]  addr = '0;
  logic [31:0] din = '0;

  logic [3:0][31:0] dout_a;
  logic [3:0]       val_a;
  logic [3:0]       rdy_a;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spram_bwe_init #(.DATA_WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8), .LATENCY(1),
    .WRITE_MODE("write_first"), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'hA5A5_0000))
  u_wf (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout_a[0]), .dout_valid(val_a[0]), .ready(rdy_a[0]));

  spram_bwe_init #(.DATA_WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8), .LATENCY(1),
    .WRITE_MODE("read_first"), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'hA5A5_0000))
  u_rf (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout_a[1]), .dout_valid(val_a[1]), .ready(rdy_a[1]));

  spram_bwe_init #(.DATA_WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8), .LATENCY(1),
    .WRITE_MODE("no_change"), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'hA5A5_0000))
  u_nc (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout_a[2]), .dout_valid(val_a[2]), .ready(rdy_a[2]));

  spram_bwe_init #(.DATA_WIDTH(32), .DEPTH(12), .BYTE_WIDTH(8), .LATENCY(3),
    .WRITE_MODE("write_first"), .INIT_ON_RESET(1'b0), .INIT_VALUE(32'h0))
  u_l3 (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout_a[3]), .dout_valid(val_a[3]), .ready(rdy_a[3]));

  // Reference model: mode 0 write_first, 1 read_first, 2 no_change.
  int          m_depth [4] = '{16, 16, 16, 12};
  int          m_lat   [4] = '{1, 1, 1, 3};
  int          m_mode  [4] = '{0, 1, 2, 0};
  bit          m_init  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] m_ival  [4] = '{32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000, 32'h0};
  logic [31:0] mmem    [4][16];
  bit          slot_v  [4][8];
  logic [31:0] slot_d  [4][8];
  logic [31:0] exp_d   [4];
  bit          exp_v   [4];
  int          cyc;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [2:0]  ev;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [31:0] ed2;
  } vec_t;

  vec_t tbl [8];

  function automatic bit ready_at(int k, int c);
    return m_init[k] ? (c >= m_depth[k] + 1) : (c >= 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      exp_d[k] = '0;
      exp_v[k] = 1'b0;
      for (int s = 0; s < 8; s++) slot_v[k][s] = 1'b0;
      if (m_init[k]) for (int a = 0; a < 16; a++) mmem[k][a] = m_ival[k];
    end
  endtask

  task automatic model_pre();
    int n;
    int s;
    logic [31:0] old;
    logic [31:0] nw;
    n = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (en && ready_at(k, cyc) && int'(addr) < m_depth[k]) begin
        old = mmem[k][addr];
        nw = old;
        for (int b = 0; b < 4; b++) if (we[b]) nw[b*8 +: 8] = din[b*8 +: 8];
        if (we != 0) mmem[k][addr] = nw;
        if (we == 0 || m_mode[k] != 2) begin
          s = (n + m_lat[k] - 1) % 8;
          slot_v[k][s] = 1'b1;
          slot_d[k][s] = (we != 0 && m_mode[k] == 0) ? nw : old;
        end
      end
    end
  endtask

  task automatic model_post();
    int s;
    cyc++;
    s = cyc % 8;
    for (int k = 0; k < 4; k++) begin
      exp_v[k] = slot_v[k][s];
      if (slot_v[k][s]) exp_d[k] = slot_d[k][s];
      slot_v[k][s] = 1'b0;
      chk($sformatf("model_ready[%0d] cyc%0d", k, cyc), 32'(rdy_a[k]), 32'(ready_at(k, cyc)));
      chk($sformatf("model_valid[%0d] cyc%0d", k, cyc), 32'(val_a[k]), 32'(exp_v[k]));
      chk($sformatf("model_dout[%0d] cyc%0d", k, cyc), dout_a[k], exp_d[k]);
    end
  endtask

  task automatic tick();
    model_pre();
    @(posedge clk);
    #1;
    model_post();
  endtask

  task automatic apply_reset();
    en = 1'b0;
    we = '0;
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_ready[%0d]", k), 32'(rdy_a[k]), 32'd0);
      chk($sformatf("rst_valid[%0d]", k), 32'(val_a[k]), 32'd0);
      chk($sformatf("rst_dout[%0d]", k), dout_a[k], 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    logic [31:0] st_d [7];
    bit          st_v [7];

    tbl[0] = '{1'b1, 4'h0, 4'd0, 32'h0,         3'b111, 32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000};
    tbl[1] = '{1'b1, 4'hF, 4'd3, 32'h1122_3344, 3'b011, 32'h1122_3344, 32'hA5A5_0000, 32'hA5A5_0000};
    tbl[2] = '{1'b1, 4'h5, 4'd3, 32'hAABB_CCDD, 3'b011, 32'h11BB_33DD, 32'h1122_3344, 32'hA5A5_0000};
    tbl[3] = '{1'b1, 4'h0, 4'd3, 32'h0,         3'b111, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD};
    tbl[4] = '{1'b1, 4'hF, 4'd5, 32'h0000_0001, 3'b011, 32'h0000_0001, 32'hA5A5_0000, 32'h11BB_33DD};
    tbl[5] = '{1'b1, 4'hF, 4'd5, 32'h0000_0002, 3'b011, 32'h0000_0002, 32'h0000_0001, 32'h11BB_33DD};
    tbl[6] = '{1'b1, 4'h0, 4'd5, 32'h0,         3'b111, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002};
    tbl[7] = '{1'b0, 4'h0, 4'd0, 32'h0,         3'b000, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002};

    for (int k = 0; k < 4; k++) for (int a = 0; a < 16; a++) mmem[k][a] = '0;

    #2;
    apply_reset();

    // Sweep window: gated write, then fill the LATENCY=3 instance (ready at once).
    low = 0;
    for (int t = 1; t <= 16; t++) begin
      if (t == 1) begin
        en = 1'b1; we = 4'hF; addr = 4'd2; din = 32'hDEAD_BEEF;
      end else if (t <= 13) begin
        en = 1'b1; we = 4'hF; addr = 4'(t - 2); din = 32'(8 + t);
      end else begin
        en = 1'b0; we = '0;
      end
      tick();
      if (!rdy_a[0]) low++;
    end
    chk("init_ready_low_cycles", 32'(low), 32'd16);
    en = 1'b0;
    tick();
    chk("init_ready_high", 32'(rdy_a[0]), 32'd1);

    for (int a = 0; a < 16; a++) begin
      en = 1'b1; we = '0; addr = 4'(a);
      tick();
      chk($sformatf("sweep_valid[%0d]", a), 32'(val_a[0]), 32'd1);
      chk($sformatf("sweep_dout[%0d]", a), dout_a[0], 32'hA5A5_0000);
    end
    en = 1'b0;
    tick();
    tick();

    st_v = '{0, 0, 1, 1, 1, 1, 0};
    st_d = '{32'd21, 32'd21, 32'd10, 32'd11, 32'd12, 32'd13, 32'd13};
    for (int t = 0; t < 7; t++) begin
      en = (t < 4); we = '0; addr = 4'(t);
      tick();
      chk($sformatf("lat3_valid[%0d]", t), 32'(val_a[3]), 32'(st_v[t]));
      chk($sformatf("lat3_dout[%0d]", t), dout_a[3], st_d[t]);
    end

    for (int i = 0; i < 8; i++) begin
      en = tbl[i].en; we = tbl[i].we; addr = tbl[i].addr; din = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_wf_valid", i), 32'(val_a[0]), 32'(tbl[i].ev[0]));
      chk($sformatf("tbl%0d_wf_dout", i), dout_a[0], tbl[i].ed0);
      chk($sformatf("tbl%0d_rf_valid", i), 32'(val_a[1]), 32'(tbl[i].ev[1]));
      chk($sformatf("tbl%0d_rf_dout", i), dout_a[1], tbl[i].ed1);
      chk($sformatf("tbl%0d_nc_valid", i), 32'(val_a[2]), 32'(tbl[i].ev[2]));
      chk($sformatf("tbl%0d_nc_dout", i), dout_a[2], tbl[i].ed2);
    end

    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
      addr = 4'($urandom);
      din = $urandom;
      tick();
    end

    // Reset mid-sweep with reads in flight on the LATENCY=3 instance.
    en = 1'b0;
    #1;
    apply_reset();
    for (int t = 1; t <= 7; t++) begin
      en = (t >= 5); we = '0; addr = 4'(t - 4);
      tick();
    end
    en = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", 32'(rdy_a[0]), 32'd0);
    chk("midrst_dout", dout_a[0], 32'd0);
    chk("midrst_l3_valid", 32'(val_a[3]), 32'd0);
    chk("midrst_l3_dout", dout_a[3], 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    low = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (!rdy_a[0]) low++;
    end
    chk("resweep_ready_low_cycles", 32'(low), 32'd16);
    tick();
    chk("resweep_ready_high", 32'(rdy_a[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
